// File: rtl/add_pipe.sv
// Carry-segmented pipelined adder/subtractor, one SEG-bit slice per stage.
// Define ADD_PIPE_SAT_EN to saturate s on signed overflow.
module add_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG;
  localparam logic [WIDTH-1:0] LO =
    (WIDTH'(1) << SEG) - WIDTH'(1);

  logic [WIDTH-1:0] a_i [NSEG];
  logic [WIDTH-1:0] b_i [NSEG];
  logic [WIDTH-1:0] s_i [NSEG];
  logic             c_i [NSEG];
  logic             v_i [NSEG];
  logic [WIDTH-1:0] s_n [NSEG];
  logic             c_n [NSEG];
  logic [WIDTH-1:0] a_p [NSEG];
  logic [WIDTH-1:0] b_p [NSEG];
  logic [WIDTH-1:0] s_q [NSEG];
  logic             c_q [NSEG];
  logic             v_q [NSEG];
  logic             ovf_q;
  logic             ovf_n;
  logic [WIDTH-1:0] s_ld;
  logic             a_msb;

  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    localparam logic [WIDTH-1:0] M = LO << (k * SEG);
    logic [SEG:0] sum;

    if (k == 0) begin : g_head
      assign a_i[k] = a;
      assign b_i[k] = sub ? ~b : b;
      assign s_i[k] = '0;
      assign c_i[k] = sub;
      assign v_i[k] = in_valid;
    end else begin : g_body
      // operands travel with the op, so slice k meets them k stages late
      assign a_i[k] = a_p[k-1];
      assign b_i[k] = b_p[k-1];
      assign s_i[k] = s_q[k-1];
      assign c_i[k] = c_q[k-1];
      assign v_i[k] = v_q[k-1];
    end

    assign sum = {1'b0, a_i[k][k*SEG +: SEG]}
               + {1'b0, b_i[k][k*SEG +: SEG]}
               + {{SEG{1'b0}}, c_i[k]};
    assign s_n[k] = (s_i[k] & ~M)
                  | (WIDTH'(sum[SEG-1:0]) << (k * SEG));
    assign c_n[k] = sum[SEG];
  end

  assign a_msb = a_i[NSEG-1][WIDTH-1];
  assign ovf_n = (a_msb == b_i[NSEG-1][WIDTH-1])
              && (s_n[NSEG-1][WIDTH-1] != a_msb);

`ifdef ADD_PIPE_SAT_EN
  assign s_ld = !ovf_n ? s_n[NSEG-1]
              : a_msb  ? {1'b1, {(WIDTH-1){1'b0}}}
              :          {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign s_ld = s_n[NSEG-1];
`endif

  // final stage doubles as the output register and only loads on valid
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSEG; k++) begin
        a_p[k] <= '0;
        b_p[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (ce) begin
      for (int k = 0; k < NSEG - 1; k++) begin
        a_p[k] <= a_i[k];
        b_p[k] <= b_i[k];
        s_q[k] <= s_n[k];
        c_q[k] <= c_n[k];
        v_q[k] <= v_i[k];
      end
      v_q[NSEG-1] <= v_i[NSEG-1];
      if (v_i[NSEG-1]) begin
        s_q[NSEG-1] <= s_ld;
        c_q[NSEG-1] <= c_n[NSEG-1];
        ovf_q       <= ovf_n;
      end
    end
  end

  assign out_valid = v_q[NSEG-1];
  assign s         = s_q[NSEG-1];
  assign cout      = c_q[NSEG-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_pipe.sv
// Directed bench for add_pipe (WIDTH=16, SEG=4).
// Expected sums are hand-computed constants.
module tb_add_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        in_valid;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic [15:0] s;
  logic        cout;
  logic        ovf;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  add_pipe #(.WIDTH(16), .SEG(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .in_valid (in_valid),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .s        (s),
    .cout     (cout),
    .ovf      (ovf)
  );

  task automatic drive(input logic v, input logic sb,
                       input logic [15:0] aa,
                       input logic [15:0] bb);
    in_valid = v;
    sub      = sb;
    a        = aa;
    b        = bb;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ce  = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    n_run++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    n_run++;
    if (s !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_s: got %h want 0000", s);
    end
    n_run++;
    if (cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cout: got %b want 0", cout);
    end
    n_run++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
    rst = 1'b0;
    ce  = 1'b1;
  endtask

  task automatic test_vectors;
    logic        v_sub [6] = '{0, 0, 0, 1, 1, 0};
    logic [15:0] v_a   [6] = '{16'h1234, 16'hFFFF, 16'h7FFF,
                               16'h0000, 16'h8000, 16'h8000};
    logic [15:0] v_b   [6] = '{16'h0001, 16'h0001, 16'h0001,
                               16'h0001, 16'h0001, 16'h8000};
`ifdef ADD_PIPE_SAT_EN
    logic [15:0] v_s   [6] = '{16'h1235, 16'h0000, 16'h7FFF,
                               16'hFFFF, 16'h8000, 16'h8000};
`else
    logic [15:0] v_s   [6] = '{16'h1235, 16'h0000, 16'h8000,
                               16'hFFFF, 16'h7FFF, 16'h0000};
`endif
    logic        v_c   [6] = '{0, 1, 0, 0, 1, 1};
    logic        v_o   [6] = '{0, 0, 1, 0, 1, 1};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, v_sub[i], v_a[i], v_b[i]);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_run++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL vec%0d_early: got %b want 0", i, out_valid);
      end
      @(posedge clk);
      #1;
      n_run++;
      if (out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL vec%0d_valid: got %b want 1", i, out_valid);
      end
      n_run++;
      if (s !== v_s[i]) begin
        n_fail++;
        $display("FAIL vec%0d_s: got %h want %h", i, s, v_s[i]);
      end
      n_run++;
      if (cout !== v_c[i]) begin
        n_fail++;
        $display("FAIL vec%0d_cout: got %b want %b", i, cout, v_c[i]);
      end
      n_run++;
      if (ovf !== v_o[i]) begin
        n_fail++;
        $display("FAIL vec%0d_ovf: got %b want %b", i, ovf, v_o[i]);
      end
      @(posedge clk);
      #1;
      n_run++;
      if (out_valid !== 1'b0 || s !== v_s[i]) begin
        n_fail++;
        $display("FAIL vec%0d_hold: got v=%b s=%h want v=0 s=%h",
                 i, out_valid, s, v_s[i]);
      end
    end
  endtask

  task automatic test_bubble;
    drive(1'b1, 1'b0, 16'h0010, 16'h0020);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 16'h0100, 16'h0200);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_run++;
    if (out_valid !== 1'b1 || s !== 16'h0030) begin
      n_fail++;
      $display("FAIL bubble_a: got v=%b s=%h want v=1 s=0030",
               out_valid, s);
    end
    @(posedge clk);
    #1;
    n_run++;
    if (out_valid !== 1'b0 || s !== 16'h0030) begin
      n_fail++;
      $display("FAIL bubble_slot: got v=%b s=%h want v=0 s=0030",
               out_valid, s);
    end
    @(posedge clk);
    #1;
    n_run++;
    if (out_valid !== 1'b1 || s !== 16'h0300) begin
      n_fail++;
      $display("FAIL bubble_b: got v=%b s=%h want v=1 s=0300",
               out_valid, s);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    logic        t_sub [8] = '{0, 0, 0, 0, 1, 1, 0, 0};
    logic [15:0] t_a   [8] = '{16'h0001, 16'h1000, 16'h00FF, 16'h0FFF,
                               16'h0005, 16'h0003, 16'hF000, 16'h1111};
    logic [15:0] t_b   [8] = '{16'h0002, 16'h2000, 16'h0001, 16'h0001,
                               16'h0003, 16'h0005, 16'h1000, 16'h2222};
    logic [15:0] t_s   [8] = '{16'h0003, 16'h3000, 16'h0100, 16'h1000,
                               16'h0002, 16'hFFFE, 16'h0000, 16'h3333};
    logic        t_c   [8] = '{0, 0, 0, 0, 1, 0, 1, 0};
    int          iss   [8];
    int          i  = 0;
    int          j  = 0;
    int          en = 0;
    logic [18:0] prev;
    prev = {out_valid, s, cout, ovf};
    for (int cyc = 0; cyc < 20; cyc++) begin
      ce = !(cyc >= 4 && cyc <= 6);
      if (i < 8) drive(1'b1, t_sub[i], t_a[i], t_b[i]);
      else in_valid = 1'b0;
      @(posedge clk);
      if (ce) begin
        en++;
        if (i < 8) begin
          iss[i] = en;
          i++;
        end
      end
      #1;
      if (!ce) begin
        n_run++;
        if ({out_valid, s, cout, ovf} !== prev) begin
          n_fail++;
          $display("FAIL b2b_frozen: got %h want %h",
                   {out_valid, s, cout, ovf}, prev);
        end
      end else if (out_valid) begin
        n_run++;
        if (j >= 8) begin
          n_fail++;
          $display("FAIL b2b_extra: got result %0d want 8 max", j + 1);
        end else begin
          if (s !== t_s[j] || cout !== t_c[j] || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_res%0d: got s=%h c=%b o=%b want s=%h c=%b o=0",
                     j, s, cout, ovf, t_s[j], t_c[j]);
          end
          n_run++;
          if (en - iss[j] !== 3) begin
            n_fail++;
            $display("FAIL b2b_lat%0d: got %0d want 4",
                     j, en - iss[j] + 1);
          end
          j++;
        end
      end
      prev = {out_valid, s, cout, ovf};
    end
    ce = 1'b1;
    n_run++;
    if (j !== 8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want 8", j);
    end
  endtask

  task automatic test_rst_flush;
    drive(1'b1, 1'b0, 16'hAAAA, 16'h1111);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 16'h1234, 16'h4321);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 16'h9000, 16'h0001);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    ce  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ce  = 1'b1;
    n_run++;
    if (out_valid !== 1'b0 || s !== 16'h0
        || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_clear: got v=%b s=%h c=%b o=%b want all 0",
               out_valid, s, cout, ovf);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      n_run++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_stale%0d: got %b want 0", k, out_valid);
      end
    end
    drive(1'b1, 1'b0, 16'h0100, 16'h0023);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_run++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_early: got %b want 0", out_valid);
    end
    @(posedge clk);
    #1;
    n_run++;
    if (out_valid !== 1'b1 || s !== 16'h0123) begin
      n_fail++;
      $display("FAIL flush_new: got v=%b s=%h want v=1 s=0123",
               out_valid, s);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_bubble();
    test_back_to_back();
    test_rst_flush();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/add_pipe.md
ADD_PIPE -- requirements
Module: add_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand and result width in bits.
REQ-002 The block SHALL have parameter SEG, default 4: bits added per pipeline stage; WIDTH SHALL be an integer multiple of SEG.
REQ-003 The block SHALL derive NSEG = WIDTH/SEG, the number of pipeline stages and the latency in enabled cycles.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all registers update on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port ce, input, 1 bit: clock enable; 0 stalls the whole pipeline.
REQ-007 The block SHALL have port in_valid, input, 1 bit: a, b and sub hold an operation.
REQ-008 The block SHALL have port sub, input, 1 bit: 0 selects a+b, 1 selects a-b.
REQ-009 The block SHALL have ports a and b, inputs, WIDTH bits each: the operands.
REQ-010 The block SHALL have port out_valid, output, 1 bit: s, cout and ovf hold a completed result.
REQ-011 The block SHALL have port s, output, WIDTH bits: the result.
REQ-012 The block SHALL have port cout, output, 1 bit: carry out of the MSB.
REQ-013 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-014 The block SHALL sample a, b, sub and in_valid on every rising clk edge with ce=1.
REQ-015 For subtraction the block SHALL use b' = ~b with carry-in 1; for addition, b' = b with carry-in 0.
REQ-016 Stage k (k = 0..NSEG-1) SHALL add bits [k*SEG +: SEG] of a and b' plus the carry registered by stage k-1.
- Stage 0 SHALL use the carry-in from REQ-015.
- Operand segments SHALL be skewed by k stages on entry.
- Result segments SHALL be deskewed so that all WIDTH bits of s leave aligned.
REQ-017 Latency SHALL be exactly NSEG enabled cycles from sampling (in_valid=1, ce=1) to the matching out_valid=1.
- Throughput SHALL be one operation per enabled cycle.
- Results SHALL leave in issue order.
REQ-018 s SHALL equal (a + b' + carry-in) mod 2^WIDTH.
REQ-019 cout SHALL be the carry out of bit WIDTH-1; for subtraction, cout=1 means no borrow.
REQ-020 ovf SHALL be 1 iff a[WIDTH-1] == b'[WIDTH-1] and the raw sum MSB differs from a[WIDTH-1].
REQ-021 A bubble (in_valid=0) SHALL propagate as out_valid=0 in its slot.
REQ-022 When out_valid=0, s, cout and ovf SHALL hold their last valid values.
REQ-023 With ce=0, every pipeline register SHALL hold, including out_valid and the outputs.
- Stall cycles SHALL NOT count toward latency.
- No operation SHALL be lost or duplicated across a stall.
REQ-024 With NSEG=1 the block SHALL behave as a single registered adder with latency 1.

Reset
REQ-025 rst=1 at a rising clk edge SHALL clear every stage valid bit, out_valid, s, cout, ovf and all internal carry registers to 0.
REQ-026 rst SHALL take priority over ce.
REQ-027 Operations in flight when rst is asserted SHALL be discarded; none SHALL emerge after reset.
REQ-028 The first operation sampled after rst deasserts SHALL complete with the normal NSEG latency.

Configuration
REQ-029 With macro ADD_PIPE_SAT_EN defined, the block SHALL replace s on signed overflow:
- positive overflow SHALL give 2^(WIDTH-1)-1;
- negative overflow SHALL give -2^(WIDTH-1);
- ovf and cout SHALL still report the raw overflow and carry.
REQ-030 Without ADD_PIPE_SAT_EN, s SHALL wrap modulo 2^WIDTH and no saturation logic SHALL be present.

Verification
REQ-031 WIDTH=16, SEG=4, ce=1: add a=0x1234, b=0x0001 -> after 4 cycles out_valid=1, s=0x1235, cout=0, ovf=0.
REQ-032 Add a=0xFFFF, b=0x0001 -> s=0x0000, cout=1, ovf=0 (carry crosses all 4 stages).
REQ-033 Add a=0x7FFF, b=0x0001 -> ovf=1, cout=0; s=0x8000 without the macro, s=0x7FFF with it.
REQ-034 Subtract a=0x0000, b=0x0001 -> s=0xFFFF, cout=0, ovf=0.
- Subtract a=0x8000, b=0x0001 -> ovf=1; s=0x7FFF without the macro, s=0x8000 with it.
REQ-035 Issue 8 back-to-back random ops with ce=0 for 3 cycles mid-stream -> 8 results in order, each matching the reference sum, each after 4 enabled cycles, outputs frozen during the stall.
REQ-036 Pulse rst for 1 cycle with 3 ops in flight -> out_valid=0 and s=0 the next cycle; no stale result appears in the following 4 cycles; a new op issued after reset completes after 4 cycles.
